// File: rtl/mdu_iter_div.sv
// Iterative radix-2 restoring divider: DIVCOPIES chained steps per cycle, signed/unsigned,
// quotient/remainder, and RV64 word variants, with valid/ready handshakes and flush.
module mdu_iter_div #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DIVCOPIES = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_x,
    input  logic [XLEN-1:0] i_d,
    input  logic            i_signed,
    input  logic            i_rem_op,
    input  logic            i_word,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned NFull = XLEN / DIVCOPIES;
    localparam int unsigned NWord = 32 / DIVCOPIES;
    localparam int unsigned CntW  = (NFull > 1) ? $clog2(NFull) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_w, r_xq, r_d_abs, r_result;
    logic [CntW-1:0] r_cnt;
    logic            r_neg_q, r_neg_r, r_rem_op, r_word;

    logic            w_word, w_x_neg, w_d_neg, w_d_zero, w_accept, w_unused_sum;
    logic [XLEN-1:0] w_x_ext, w_d_ext, w_x_abs, w_d_abs, w_xq_init, w_div0_sel, w_div0_result;
    logic [XLEN-1:0] w_w_next, w_xq_next, w_q_fix, w_r_fix, w_sel, w_post;

    // Low 32 bits of v, upper bits filled with v[31] when sgn, else zero.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] o;
        for (int i = 0; i < XLEN; i++) begin
            o[i] = (i < 32) ? v[i] : (sgn & v[31]);
        end
        return o;
    endfunction

    // Operand conditioning on the acceptance cycle
    assign w_word     = i_word & (XLEN == 64);
    assign w_x_ext    = w_word ? ext32(i_x, i_signed) : i_x;
    assign w_d_ext    = w_word ? ext32(i_d, i_signed) : i_d;
    assign w_x_neg    = i_signed & w_x_ext[XLEN-1];
    assign w_d_neg    = i_signed & w_d_ext[XLEN-1];
    assign w_x_abs    = w_x_neg ? -w_x_ext : w_x_ext;
    assign w_d_abs    = w_d_neg ? -w_d_ext : w_d_ext;
    assign w_d_zero   = (w_d_ext == '0);
    assign w_xq_init  = w_word ? (w_x_abs << (XLEN / 2)) : w_x_abs;
    assign w_div0_sel = i_rem_op ? w_x_ext : '1;
    assign w_div0_result = w_word ? ext32(w_div0_sel, 1'b1) : w_div0_sel;
    assign w_accept   = (r_state == StIdle) & i_in_valid & ~i_flush;

    // Chain of restoring steps; carry out of W' = Wshift + ~D + 1 is the quotient bit.
    always_comb begin : p_steps
        logic [XLEN-1:0] v_w, v_xq;
        logic [XLEN:0]   v_shift;
        logic [XLEN+1:0] v_sum;
        v_w          = r_w;
        v_xq         = r_xq;
        v_shift      = '0;
        v_sum        = '0;
        w_unused_sum = 1'b0;
        for (int i = 0; i < DIVCOPIES; i++) begin
            v_shift = {v_w, v_xq[XLEN-1]};
            v_sum   = {1'b0, v_shift} + {1'b0, ~{1'b0, r_d_abs}} + {{(XLEN+1){1'b0}}, 1'b1};
            v_xq    = {v_xq[XLEN-2:0], v_sum[XLEN+1]};
            v_w     = v_sum[XLEN+1] ? v_sum[XLEN-1:0] : v_shift[XLEN-1:0];
            w_unused_sum = w_unused_sum ^ v_sum[XLEN];
        end
        w_w_next  = v_w;
        w_xq_next = v_xq;
    end

    assign w_q_fix = r_neg_q ? -w_xq_next : w_xq_next;
    assign w_r_fix = r_neg_r ? -w_w_next : w_w_next;
    assign w_sel   = r_rem_op ? w_r_fix : w_q_fix;
    assign w_post  = r_word ? ext32(w_sel, 1'b1) : w_sel;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_d_zero ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (i_flush) begin
                    w_state_next = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (i_flush || i_out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_w      <= '0;
            r_xq     <= '0;
            r_d_abs  <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem_op <= 1'b0;
            r_word   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_w      <= '0;
                r_xq     <= w_xq_init;
                r_d_abs  <= w_d_abs;
                r_cnt    <= w_word ? CntW'(NWord - 1) : CntW'(NFull - 1);
                r_neg_q  <= w_x_neg ^ w_d_neg;
                r_neg_r  <= w_x_neg;
                r_rem_op <= i_rem_op;
                r_word   <= w_word;
                if (w_d_zero) begin
                    r_result <= w_div0_result;
                end
            end else if ((r_state == StBusy) && !i_flush) begin
                r_w   <= w_w_next;
                r_xq  <= w_xq_next;
                r_cnt <= r_cnt - CntW'(1);
                if (r_cnt == '0) begin
                    r_result <= w_post;
                end
            end
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_result    = r_result;

endmodule

// File: tb/tb_mdu_iter_div.sv
// Bench for mdu_iter_div: XLEN=32 and XLEN=64 instances, directed table, corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_mdu_iter_div;

    logic        clk = 1'b0;
    logic        reset, flush, out_ready, in_valid32, in_valid64, sgn, rem, word;
    logic [63:0] x, d;
    logic        in_ready32, in_ready64, out_valid32, out_valid64;
    logic [31:0] result32;
    logic [63:0] result64;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mdu_iter_div #(.XLEN(32), .DIVCOPIES(4)) u_dut32 (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid32),
        .o_in_ready(in_ready32), .i_x(x[31:0]), .i_d(d[31:0]), .i_signed(sgn),
        .i_rem_op(rem), .i_word(1'b0), .o_out_valid(out_valid32), .i_out_ready(out_ready),
        .o_result(result32)
    );

    mdu_iter_div #(.XLEN(64), .DIVCOPIES(4)) u_dut64 (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid64),
        .o_in_ready(in_ready64), .i_x(x), .i_d(d), .i_signed(sgn),
        .i_rem_op(rem), .i_word(word), .o_out_valid(out_valid64), .i_out_ready(out_ready),
        .o_result(result64)
    );

    typedef struct {
        bit          is64;
        logic [63:0] x;
        logic [63:0] d;
        bit          s;
        bit          r;
        bit          w;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: divide the operation-width values with ordinary integer arithmetic.
    function automatic logic [63:0] ref_div(input bit is64, input logic [63:0] xi,
                                            input logic [63:0] di, input bit s, input bit r,
                                            input bit w);
        logic [63:0] xm, dm, q, rr, res;
        longint      xs, ds;
        bit          wd = w && is64;
        if (!is64 || wd) begin
            xm = s ? {{32{xi[31]}}, xi[31:0]} : {32'h0, xi[31:0]};
            dm = s ? {{32{di[31]}}, di[31:0]} : {32'h0, di[31:0]};
        end else begin
            xm = xi;
            dm = di;
        end
        if (dm == 64'h0) begin
            q  = '1;
            rr = xm;
        end else if (s) begin
            if (xm == 64'h8000_0000_0000_0000 && dm == '1) begin
                q  = xm;
                rr = 64'h0;
            end else begin
                xs = xm;
                ds = dm;
                q  = xs / ds;
                rr = xs % ds;
            end
        end else begin
            q  = xm / dm;
            rr = xm % dm;
        end
        res = r ? rr : q;
        if (wd) res = {{32{res[31]}}, res[31:0]};
        else if (!is64) res = {32'h0, res[31:0]};
        return res;
    endfunction

    function automatic int exp_lat(input bit is64, input logic [63:0] di, input bit w);
        if ((!is64 || w) ? (di[31:0] == 32'h0) : (di == 64'h0)) return 1;
        return (is64 && !w) ? 17 : 9;
    endfunction

    task automatic run_op(input bit is64, input logic [63:0] xi, input logic [63:0] di,
                          input bit s, input bit r, input bit w,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        x = xi; d = di; sgn = s; rem = r; word = w; out_ready = 1'b1;
        if (is64) in_valid64 = 1'b1;
        else in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid64 = 1'b0; in_valid32 = 1'b0;
        // Operands must be ignored once accepted
        x = ~xi; d = ~di; sgn = ~s; rem = ~r;
        lat = 1;
        while (!(is64 ? out_valid64 : out_valid32) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        res = is64 ? result64 : {32'h0, result32};
    endtask

    initial begin
        logic [63:0] res, xi, di;
        int          lat, seen;
        bit          is64, s, r, w;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid32 = 1'b0; in_valid64 = 1'b0;
        sgn = 1'b0; rem = 1'b0; word = 1'b0; x = '0; d = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready32", 64'(in_ready32), 64'd1);
        check("reset out_valid32", 64'(out_valid32), 64'd0);
        check("reset result32", 64'(result32), 64'd0);
        check("reset in_ready64", 64'(in_ready64), 64'd1);
        check("reset out_valid64", 64'(out_valid64), 64'd0);
        check("reset result64", result64, 64'd0);
        reset = 1'b0;

        vecs[0]  = '{1'b0, 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 9};
        vecs[1]  = '{1'b0, 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 9};
        vecs[2]  = '{1'b0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFD, 9};
        vecs[3]  = '{1'b0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF, 9};
        vecs[4]  = '{1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 9};
        vecs[5]  = '{1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'h0, 9};
        vecs[6]  = '{1'b0, 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF, 1};
        vecs[7]  = '{1'b0, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 64'd5, 1};
        vecs[8]  = '{1'b1, 64'h1234_5678_FFFF_FFF0, 64'd4, 1'b1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFC, 9};
        vecs[9]  = '{1'b1, 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 17};
        vecs[10] = '{1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 9};
        vecs[11] = '{1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 9};
        vecs[12] = '{1'b1, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 1'b0, 64'h0, 17};
        vecs[13] = '{1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 1};

        foreach (vecs[i]) begin
            run_op(vecs[i].is64, vecs[i].x, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].w,
                   res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Flush three cycles into BUSY
        @(negedge clk);
        x = 64'd100; d = 64'd7; sgn = 1'b0; rem = 1'b0; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy in_ready", 64'(in_ready32), 64'd1);
        check("flush busy out_valid", 64'(out_valid32), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid32) seen++;
        end
        check("flush busy out_valid never", 64'(seen), 64'd0);
        run_op(1'b0, 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat);
        check("after flush result", res, 64'd14);
        check("after flush latency", 64'(lat), 64'd9);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1; in_valid32 = 1'b1; x = 64'd9; d = 64'd3;
        @(negedge clk);
        flush = 1'b0; in_valid32 = 1'b0;
        check("flush idle in_ready", 64'(in_ready32), 64'd1);

        // OutReady held low in DONE; new operands offered meanwhile must be ignored
        @(negedge clk);
        x = 64'd100; d = 64'd7; sgn = 1'b0; rem = 1'b0; out_ready = 1'b0; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("hold latency", 64'(lat), 64'd9);
        for (int k = 0; k < 5; k++) begin
            check("hold result", 64'(result32), 64'd14);
            check("hold out_valid", 64'(out_valid32), 64'd1);
            check("hold in_ready", 64'(in_ready32), 64'd0);
            in_valid32 = 1'b1; x = 64'd3; d = 64'd1;
            @(negedge clk);
        end
        in_valid32 = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("consume out_valid", 64'(out_valid32), 64'd0);
        check("consume in_ready", 64'(in_ready32), 64'd1);

        // Flush in DONE discards the result
        @(negedge clk);
        x = 64'd50; d = 64'd5; word = 1'b0; out_ready = 1'b0; in_valid64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid64 = 1'b0;
        lat = 1;
        while (!out_valid64 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("flush done latency", 64'(lat), 64'd17);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        check("flush done out_valid", 64'(out_valid64), 64'd0);
        check("flush done in_ready", 64'(in_ready64), 64'd1);

        // Reset mid-operation clears everything, including the held result
        @(negedge clk);
        x = 64'd100; d = 64'd7; in_valid64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid64 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset in_ready", 64'(in_ready64), 64'd1);
        check("midreset out_valid", 64'(out_valid64), 64'd0);
        check("midreset result", result64, 64'd0);

        for (int i = 0; i < 300; i++) begin
            is64 = (i < 200);
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w = is64 ? 1'($urandom_range(0, 1)) : 1'b0;
            xi = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: xi = xi >> $urandom_range(0, 63);
                1: xi = (is64 && !w) ? 64'h8000_0000_0000_0000 : {xi[63:32], 32'h8000_0000};
                default: ;
            endcase
            di = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0: di = {di[63:32], 32'h0};
                1: di = '1;
                2: di = 64'($urandom_range(1, 20));
                3: di = di >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op(is64, xi, di, s, r, w, res, lat);
            check($sformatf("rand%0d result x=%h d=%h s%0d r%0d w%0d", i, xi, di, s, r, w),
                  res, ref_div(is64, xi, di, s, r, w));
            check($sformatf("rand%0d latency", i), 64'(lat), 64'(exp_lat(is64, di, w)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
